// File: rtl/data_mem_responder.sv
// data_mem_responder: responder side of the CPU data-memory port.
// Serves byte-enabled stores and word loads from a word RAM plus a 16-byte
// register window (split-read cycle counter, LED register, scratch register).
// Unmapped accesses and stores to read-only registers raise a sticky error.
module data_mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
    parameter int          LED_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       data_mem_we_i,
    input  logic [31:0]      data_mem_address_i,
    input  logic [31:0]      data_mem_write_i,
    output logic [31:0]      data_mem_read_o,
    output logic [LED_W-1:0] leds_o,
    output logic             bus_err_o,
    input  logic             bus_err_clr_i
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [31:0] RAM_BYTES = 32'(4) << DEPTH_LOG2;
    localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'd16;

    // Register window offsets (word index within the window, MMIO_BASE is 16-byte aligned)
    localparam logic [1:0] OFF_CNT_LO  = 2'd0;
    localparam logic [1:0] OFF_CNT_HI  = 2'd1;
    localparam logic [1:0] OFF_LED     = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    logic [31:0] mem [0:DEPTH-1];

    logic [31:0] read_q,    read_d;
    logic [63:0] cnt_q,     cnt_d;
    logic [31:0] shadow_q,  shadow_d;
    logic [31:0] led_q,     led_d;
    logic [31:0] scratch_q, scratch_d;
    logic        err_q,     err_d;

    logic                  is_ram;
    logic                  is_mmio;
    logic [1:0]            mmio_off;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [3:0]            ram_we;
    logic                  err_now;

    // Byte-lane merge of new store data into an existing word
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  we);
        logic [31:0] res;
        res = old_w;
        for (int n = 0; n < 4; n++) begin
            if (we[n]) res[8*n +: 8] = new_w[8*n +: 8];
        end
        return res;
    endfunction

    assign is_ram   = (data_mem_address_i < RAM_BYTES);
    assign is_mmio  = (data_mem_address_i >= MMIO_BASE) && (data_mem_address_i < MMIO_END);
    assign mmio_off = data_mem_address_i[3:2];
    assign ram_idx  = data_mem_address_i[DEPTH_LOG2+1:2];

    // Decode the presented address every cycle: next read word, register updates, error detection
    always_comb begin
        read_d    = 32'h0000_0000;
        cnt_d     = cnt_q + 64'd1;
        shadow_d  = shadow_q;
        led_d     = led_q;
        scratch_d = scratch_q;
        ram_we    = 4'b0000;
        err_now   = 1'b0;

        if (is_ram) begin
            // Write-first: a load of the word being stored sees the merged result
            ram_we = data_mem_we_i;
            read_d = lane_merge(mem[ram_idx], data_mem_write_i, data_mem_we_i);
        end else if (is_mmio) begin
            case (mmio_off)
                OFF_CNT_LO: begin
                    // Latch the high half now so a later CNT_HI read is coherent with this low half
                    read_d   = cnt_q[31:0];
                    shadow_d = cnt_q[63:32];
                    err_now  = |data_mem_we_i;
                end
                OFF_CNT_HI: begin
                    read_d  = shadow_q;
                    err_now = |data_mem_we_i;
                end
                OFF_LED: begin
                    led_d  = lane_merge(led_q, data_mem_write_i, data_mem_we_i);
                    read_d = led_d;
                end
                OFF_SCRATCH: begin
                    scratch_d = lane_merge(scratch_q, data_mem_write_i, data_mem_we_i);
                    read_d    = scratch_d;
                end
                default: read_d = 32'h0000_0000;
            endcase
        end else begin
            // Every cycle is a load, so an unmapped address always flags an error
            err_now = 1'b1;
        end

        // A new error outranks a clear in the same cycle
        if (err_now)            err_d = 1'b1;
        else if (bus_err_clr_i) err_d = 1'b0;
        else                    err_d = err_q;
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (ram_we[n]) mem[ram_idx][8*n +: 8] <= data_mem_write_i[8*n +: 8];
        end
    end

    // Registered outputs, counter and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_q    <= 32'h0000_0000;
            cnt_q     <= 64'd0;
            shadow_q  <= 32'h0000_0000;
            led_q     <= 32'h0000_0000;
            scratch_q <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            read_q    <= read_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            err_q     <= err_d;
        end
    end

    assign data_mem_read_o = read_q;
    assign leds_o          = led_q[LED_W-1:0];
    assign bus_err_o       = err_q;

endmodule
